elevator_sim_core: RTL
======================

Name:
elevator_sim_core

Overview:
Parametrised elevator-motion generator that replaces the fixed free-running destination counter feeding the VGA display. It models NUM_CARS cars, each with its own state machine, driven by a clock-enable prescaler rather than a derived clock. Targets come from a selectable pattern mode. Outputs are frame-synchronised shadow registers, so the vgaController never sees a value change mid-frame.

Parameters:
NUM_FLOORS, 8, floors per shaft (2..256); FW = $clog2(NUM_FLOORS), derived
NUM_CARS, 2, number of independent cars (1..4)
TICK_DIV, 16'd25000, clk cycles per simulation tick (>=1)
DOOR_TICKS, 4, ticks a car holds DOOR_OPEN (>=1)

Ports:
clk  in  1  single clock (pixel clock domain)
rst  in  1  synchronous, active-high reset
en  in  1  1 = prescaler runs; 0 = freeze all sim state (shadow updates still occur)
mode  in  2  target source: 0 SWEEP, 1 PINGPONG, 2 RANDOM, 3 EXTERNAL
seed  in  8  LFSR seed, loaded at reset; seed==0 loads 8'h01
dest_in  in  NUM_CARS*FW  external targets (car k at [k*FW +: FW]), used in mode 3
frame_start  in  1  one-cycle pulse at vsync start
floor_out  out  NUM_CARS*FW  displayed current floor per car
dest_out  out  NUM_CARS*FW  displayed target floor per car
state_out  out  NUM_CARS*2  displayed car state (sim_state encoding)
tick  out  1  one-cycle strobe on each sim tick (debug)

Behaviour:
- Reset (rst=1 on a clk edge): prescaler=0, tick=0; every car is floor=0, target=0, state IDLE, door_cnt=0, dir=up. LFSR is loaded with seed (or 8'h01). All shadow outputs are 0.
- Prescaler: counts 0..TICK_DIV-1 while en=1 and asserts tick for one cycle when it wraps. en=0 holds the count. With TICK_DIV=1, tick is high on every enabled cycle.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances once per tick.
- The car FSM evaluates only on tick cycles.
  - IDLE: fetch a new target t. If t>floor, go to UP. If t<floor, go to DOWN. If t==floor, stay in IDLE (re-fetch on the next tick).
  - UP/DOWN: floor +/-1 per tick. When the updated floor equals target, go to DOOR (same tick) and set door_cnt=DOOR_TICKS-1.
  - DOOR: decrement door_cnt each tick. At 0, go to IDLE on the next tick.
  - Target is latched at fetch. A mode change mid-trip takes effect at the next fetch only.
- State encoding is IDLE=2'b00, UP=2'b01, DOWN=2'b10, DOOR=2'b11.
- Target fetch by mode:
  - SWEEP: floor+1, wrapping to 0 after NUM_FLOORS-1.
  - PINGPONG: floor+1 if dir=up, else floor-1. At the top floor, dir flips to down; at floor 0, dir flips to up.
  - RANDOM: r = (lfsr ^ (8'h35*k))[FW-1:0]. If r>=NUM_FLOORS, use r-NUM_FLOORS; one subtraction always suffices.
  - EXTERNAL: the car k slice of dest_in. If the value is >=NUM_FLOORS, clamp to NUM_FLOORS-1.
- Shadow outputs:
  - On a cycle with frame_start=1, floor_out/dest_out/state_out load the internal values as they stand before that edge's update.
  - Outputs change only on the edge after frame_start; latency is 1 cycle.
  - If tick and frame_start coincide, the pre-tick values are displayed.
- Reset mid-trip returns every car to floor 0, IDLE, immediately (on the next edge); no door sequence is run.
- All floor arithmetic is FW bits wide, and floor never leaves 0..NUM_FLOORS-1.

Decomposition:
- Package elevator_pkg holds:
  - car_state_t enum (IDLE, UP, DOWN, DOOR; 2-bit, values above);
  - mode_t enum (SWEEP, PINGPONG, RANDOM, EXTERNAL);
  - LFSR_TAPS constant;
  - LFSR_DEFAULT = 8'h01.
- One sub-module, elevator_car, holds the per-car FSM, floor, target, dir and door_cnt. It takes tick and a fetched target and is instanced NUM_CARS times via generate.
- The prescaler, LFSR, target-select mux and shadow registers stay in the top.

Test Plan:
- Bench configuration for all scenarios: NUM_FLOORS=8, NUM_CARS=2, TICK_DIV=4, DOOR_TICKS=2.
- Reset: hold rst 3 cycles, then pulse frame_start -> floor_out=0, dest_out=0, state_out=0, tick=0; tick first rises on the 4th cycle after rst falls.
- SWEEP, car0 from floor 0: tick1 target=1 UP; tick2 floor=1 DOOR; tick3 door_cnt=0; tick4 IDLE; tick5 target=2. After floor 7 the target is 0 and the car moves DOWN for 7 ticks.
- PINGPONG: car reaches floor 7, then its next target is 6 with state DOWN. At floor 0 the next target is 1 with state UP; floor stays within 0..7 over 2000 ticks.
- RANDOM with seed=0: LFSR internal value is 8'h01 after reset. Over 1000 ticks all dest values are <8, and car0 and car1 targets differ on at least one fetch.
- EXTERNAL with dest_in={3'd5,3'd2}: car0 goes UP to 2 and car1 goes UP to 5. Changing dest_in mid-trip does not alter the latched target.
- Frame sync: with frame_start held low for 50 ticks, outputs are unchanged. A frame_start pulse coincident with tick shows the pre-tick floor; en=0 freezes floor while frame_start still refreshes.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the elevator motion generator.
package elevator_pkg;

  // Car state encoding; this is also the value shown on state_out.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10,
    DOOR = 2'b11
  } car_state_t;

  // Target source selected by the mode input.
  typedef enum logic [1:0] {
    SWEEP    = 2'b00,
    PINGPONG = 2'b01,
    RANDOM   = 2'b10,
    EXTERNAL = 2'b11
  } mode_t;

  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS    = 8'hB8;
  // An all-zero LFSR would lock up, so a zero seed is replaced by this.
  localparam logic [7:0] LFSR_DEFAULT = 8'h01;

  // One shift of the LFSR: shift left, feedback is parity of the tapped bits.
  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/elevator_car.sv
// One elevator car: state machine, current floor, latched target,
// travel direction and door hold counter. Everything advances only
// on cycles where step is high.
module elevator_car
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 8,
  parameter int DOOR_TICKS = 4,
  localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic [FW-1:0] fetch_target,
  output logic [FW-1:0] floor,
  output logic [FW-1:0] target,
  output car_state_t    state,
  output logic          dir
);

  localparam int DW = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
  localparam logic [DW-1:0] DOOR_LOAD = DW'(DOOR_TICKS - 1);

  car_state_t    state_n;
  logic [FW-1:0] floor_n;
  logic [FW-1:0] target_n;
  logic          dir_n;
  logic [DW-1:0] door_cnt;
  logic [DW-1:0] door_n;

  // Register the car state; reset parks the car at floor 0, doors shut.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      floor    <= '0;
      target   <= '0;
      dir      <= 1'b1;
      door_cnt <= '0;
    end else begin
      state    <= state_n;
      floor    <= floor_n;
      target   <= target_n;
      dir      <= dir_n;
      door_cnt <= door_n;
    end
  end

  // Next-state logic. Direction follows the last departure, so at the
  // top floor a down target flips it and at floor 0 an up target flips it.
  always_comb begin
    state_n  = state;
    floor_n  = floor;
    target_n = target;
    dir_n    = dir;
    door_n   = door_cnt;
    if (step) begin
      case (state)
        IDLE: begin
          target_n = fetch_target;
          if (fetch_target > floor) begin
            state_n = UP;
            dir_n   = 1'b1;
          end else if (fetch_target < floor) begin
            state_n = DOWN;
            dir_n   = 1'b0;
          end
        end
        UP: begin
          floor_n = floor + 1'b1;
          if (floor_n == target) begin
            state_n = DOOR;
            door_n  = DOOR_LOAD;
          end
        end
        DOWN: begin
          floor_n = floor - 1'b1;
          if (floor_n == target) begin
            state_n = DOOR;
            door_n  = DOOR_LOAD;
          end
        end
        default: begin
          if (door_cnt == '0) begin
            state_n = IDLE;
          end else begin
            door_n = door_cnt - 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/elevator_sim_core.sv
// Elevator motion generator for the VGA display: tick prescaler, LFSR,
// per-car target selection, NUM_CARS car instances and frame-synchronised
// shadow outputs so the display never sees a mid-frame change.
module elevator_sim_core
  import elevator_pkg::*;
#(
  parameter int          NUM_FLOORS = 8,
  parameter int          NUM_CARS   = 2,
  parameter int unsigned TICK_DIV   = 16'd25000,
  parameter int          DOOR_TICKS = 4,
  localparam int FW = (NUM_FLOORS > 1) ? $clog2(NUM_FLOORS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [1:0]             mode,
  input  logic [7:0]             seed,
  input  logic [NUM_CARS*FW-1:0] dest_in,
  input  logic                   frame_start,
  output logic [NUM_CARS*FW-1:0] floor_out,
  output logic [NUM_CARS*FW-1:0] dest_out,
  output logic [NUM_CARS*2-1:0]  state_out,
  output logic                   tick
);

  localparam int            PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PW_TOP = PW'(TICK_DIV - 1);
  localparam logic [FW-1:0] TOP    = FW'(NUM_FLOORS - 1);
  localparam logic [FW:0]   NF_CMP = (FW + 1)'(NUM_FLOORS);

  logic [PW-1:0]          pre_cnt;
  logic [7:0]             lfsr;
  logic                   step;
  mode_t                  mode_sel;
  logic [NUM_CARS*FW-1:0] floor_bus;
  logic [NUM_CARS*FW-1:0] target_bus;
  logic [NUM_CARS*2-1:0]  state_bus;

  // A tick that lands while en is low is dropped, so en=0 freezes the cars.
  assign step     = tick & en;
  assign mode_sel = mode_t'(mode);

  // Prescaler: count while enabled, strobe tick for one cycle on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (en) begin
        if (pre_cnt == PW_TOP) begin
          pre_cnt <= '0;
          tick    <= 1'b1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  end

  // LFSR: seeded at reset, one shift per sim tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= (seed == 8'h00) ? LFSR_DEFAULT : seed;
    end else if (step) begin
      lfsr <= lfsr_next(lfsr);
    end
  end

  for (genvar k = 0; k < NUM_CARS; k++) begin : g_car
    localparam logic [7:0] SALT = 8'(8'h35 * k);

    logic [FW-1:0] car_floor;
    logic [FW-1:0] car_target;
    logic [FW-1:0] fetch;
    logic [FW-1:0] rnd;
    logic [FW-1:0] ext;
    car_state_t    car_state;
    logic          car_dir;

    assign rnd = FW'(lfsr ^ SALT);
    assign ext = dest_in[k*FW +: FW];

    // Candidate target for this car; only used when the car is IDLE.
    always_comb begin
      fetch = car_floor;
      case (mode_sel)
        SWEEP: begin
          fetch = (car_floor == TOP) ? '0 : car_floor + 1'b1;
        end
        PINGPONG: begin
          if (car_floor == TOP) begin
            fetch = car_floor - 1'b1;
          end else if (car_floor == '0) begin
            fetch = car_floor + 1'b1;
          end else if (car_dir) begin
            fetch = car_floor + 1'b1;
          end else begin
            fetch = car_floor - 1'b1;
          end
        end
        RANDOM: begin
          fetch = ({1'b0, rnd} >= NF_CMP) ? rnd - FW'(NUM_FLOORS) : rnd;
        end
        default: begin
          fetch = ({1'b0, ext} >= NF_CMP) ? TOP : ext;
        end
      endcase
    end

    elevator_car #(
      .NUM_FLOORS (NUM_FLOORS),
      .DOOR_TICKS (DOOR_TICKS)
    ) u_car (
      .clk          (clk),
      .rst          (rst),
      .step         (step),
      .fetch_target (fetch),
      .floor        (car_floor),
      .target       (car_target),
      .state        (car_state),
      .dir          (car_dir)
    );

    assign floor_bus[k*FW +: FW]  = car_floor;
    assign target_bus[k*FW +: FW] = car_target;
    assign state_bus[k*2 +: 2]    = car_state;
  end

  // Shadow registers: capture the pre-edge internal values on frame_start.
  always_ff @(posedge clk) begin
    if (rst) begin
      floor_out <= '0;
      dest_out  <= '0;
      state_out <= '0;
    end else if (frame_start) begin
      floor_out <= floor_bus;
      dest_out  <= target_bus;
      state_out <= state_bus;
    end
  end

endmodule
